msg_pkt_serializer: RTL and testbench

//  Parametrised, sequential successor of the combinational message-to-packet stage.
//  - Captures one WB bus message: burst data, address, byte selects, WE and reply flag.
//  - Emits it toward the NoC router as a flit stream: one header flit, then 0..MAX_BURST data flits.
//  - Flow control is valid/ready on both sides; sits between the WB slave/master interfaces and the NIC output port.

---
 rtl/msg_pkt_serializer.sv | 214 +++++++++++++++++++++
 tb/tb_msg_pkt_serializer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_pkt_serializer.sv
// Message-to-packet serializer: captures one WB bus message and emits it to the NoC
// as a header flit followed by 0..MAX_BURST data flits, valid/ready on both sides.
// Optional feature macro: MSG2PKT_CHECKSUM_EN appends an XOR checksum TAIL flit.
module msg_pkt_serializer #(
    parameter int unsigned BUS_DATA_WIDTH    = 32,
    parameter int unsigned BUS_ADDRESS_WIDTH = 32,
    parameter int unsigned BUS_SEL_WIDTH     = 4,
    parameter int unsigned MAX_BURST         = 4,
    parameter int unsigned FLIT_WIDTH        = 64,
    localparam int unsigned LEN_W            = $clog2(MAX_BURST + 1)
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic                                msg_valid_i,
    output logic                                msg_ready_o,
    input  logic [MAX_BURST*BUS_DATA_WIDTH-1:0] data_i,
    input  logic [MAX_BURST*BUS_SEL_WIDTH-1:0]  sel_i,
    input  logic [BUS_ADDRESS_WIDTH-1:0]        address_i,
    input  logic [LEN_W-1:0]                    burst_len_i,
    input  logic                                WE_I,
    input  logic                                reply_i,
    output logic [FLIT_WIDTH-1:0]               flit_o,
    output logic                                flit_valid_o,
    input  logic                                flit_ready_i,
    output logic                                len_err_o
);

    localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [1:0] TypeHead     = 2'b10;
    localparam logic [1:0] TypeBody     = 2'b00;
    localparam logic [1:0] TypeTail     = 2'b01;
    localparam logic [1:0] TypeHeadTail = 2'b11;

`ifdef MSG2PKT_CHECKSUM_EN
    typedef enum logic [1:0] {StIdle, StHead, StBody, StChk} state_e;
`else
    typedef enum logic [1:0] {StIdle, StHead, StBody} state_e;
`endif

    state_e                       state_q, state_d;
    logic [BUS_DATA_WIDTH-1:0]    data_q [MAX_BURST];
    logic [BUS_SEL_WIDTH-1:0]     sel_q  [MAX_BURST];
    logic [BUS_ADDRESS_WIDTH-1:0] addr_q;
    logic                         we_q, reply_q, len_err_q;
    logic [LEN_W-1:0]             len_q, nd_q;
    logic [CNT_W-1:0]             cnt_q, cnt_d;

    logic                         accept, xfer, last_word;
    logic [LEN_W-1:0]             len_sat, nd_in;
    logic [FLIT_WIDTH-1:0]        flit;
    logic                         flit_valid;

    assign accept    = msg_valid_i & (state_q == StIdle);
    assign xfer      = flit_valid & flit_ready_i;
    assign len_sat   = (burst_len_i > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : burst_len_i;
    // Read requests carry only a header; len still reports the requested word count.
    assign nd_in     = (WE_I | reply_i) ? len_sat : '0;
    assign last_word = (LEN_W'(cnt_q) == (nd_q - LEN_W'(1)));

    // Capture the whole message on accept; inputs are ignored afterwards.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned k = 0; k < MAX_BURST; k++) begin
                data_q[k] <= '0;
                sel_q[k]  <= '0;
            end
            addr_q    <= '0;
            we_q      <= 1'b0;
            reply_q   <= 1'b0;
            len_q     <= '0;
            nd_q      <= '0;
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= accept & (burst_len_i > LEN_W'(MAX_BURST));
            if (accept) begin
                for (int unsigned k = 0; k < MAX_BURST; k++) begin
                    data_q[k] <= data_i[k*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
                    sel_q[k]  <= sel_i[k*BUS_SEL_WIDTH +: BUS_SEL_WIDTH];
                end
                addr_q  <= address_i;
                we_q    <= WE_I;
                reply_q <= reply_i;
                len_q   <= len_sat;
                nd_q    <= nd_in;
            end
        end
    end

    // FSM state and data-word counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MSG2PKT_CHECKSUM_EN
    logic [FLIT_WIDTH-3:0] csum_q;

    // Running XOR of the non-type bits of every flit transferred in this packet.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= '0;
        end else if (xfer) begin
            csum_q <= csum_q ^ flit[FLIT_WIDTH-3:0];
        end
    end
`endif

    // Next-state logic: advance only on a flit transfer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StHead;
                    cnt_d   = '0;
                end
            end
            StHead: begin
                if (xfer) begin
                    if (nd_q != '0) begin
                        state_d = StBody;
                        cnt_d   = '0;
                    end else begin
`ifdef MSG2PKT_CHECKSUM_EN
                        state_d = StChk;
`else
                        state_d = StIdle;
`endif
                    end
                end
            end
            StBody: begin
                if (xfer) begin
                    if (last_word) begin
`ifdef MSG2PKT_CHECKSUM_EN
                        state_d = StChk;
`else
                        state_d = StIdle;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef MSG2PKT_CHECKSUM_EN
            StChk: begin
                if (xfer) begin
                    state_d = StIdle;
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Flit formatting from the captured message; stable while stalled since nothing
    // captured changes outside IDLE.
    always_comb begin
        flit       = '0;
        flit_valid = 1'b0;
        unique case (state_q)
            StHead: begin
                flit_valid = 1'b1;
`ifdef MSG2PKT_CHECKSUM_EN
                flit[FLIT_WIDTH-1 -: 2] = TypeHead;
`else
                flit[FLIT_WIDTH-1 -: 2] = (nd_q == '0) ? TypeHeadTail : TypeHead;
`endif
                flit[FLIT_WIDTH-3]             = we_q;
                flit[FLIT_WIDTH-4]             = reply_q;
                flit[FLIT_WIDTH-5 -: LEN_W]    = len_q;
                flit[BUS_ADDRESS_WIDTH-1:0]    = addr_q;
            end
            StBody: begin
                flit_valid = 1'b1;
`ifdef MSG2PKT_CHECKSUM_EN
                flit[FLIT_WIDTH-1 -: 2] = TypeBody;
`else
                flit[FLIT_WIDTH-1 -: 2] = last_word ? TypeTail : TypeBody;
`endif
                flit[BUS_DATA_WIDTH +: BUS_SEL_WIDTH] = sel_q[cnt_q];
                flit[BUS_DATA_WIDTH-1:0]              = data_q[cnt_q];
            end
`ifdef MSG2PKT_CHECKSUM_EN
            StChk: begin
                flit_valid               = 1'b1;
                flit[FLIT_WIDTH-1 -: 2]  = TypeTail;
                flit[FLIT_WIDTH-3:0]     = csum_q;
            end
`endif
            default: begin
                flit       = '0;
                flit_valid = 1'b0;
            end
        endcase
    end

    assign msg_ready_o  = (state_q == StIdle);
    assign flit_o       = flit;
    assign flit_valid_o = flit_valid;
    assign len_err_o    = len_err_q;

endmodule

// File: tb/tb_msg_pkt_serializer.sv
// Self-checking bench for msg_pkt_serializer (default parameters): directed table,
// hand-written multi-cycle sequences and randomized traffic against a flit-list model.
module tb_msg_pkt_serializer;

`ifdef MSG2PKT_CHECKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         msg_valid;
    logic         msg_ready;
    logic [127:0] data;
    logic [15:0]  sel;
    logic [31:0]  addr;
    logic [2:0]   burst_len;
    logic         we;
    logic         reply;
    logic [63:0]  flit;
    logic         flit_valid;
    logic         flit_ready;
    logic         len_err;

    msg_pkt_serializer dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .msg_valid_i  (msg_valid),
        .msg_ready_o  (msg_ready),
        .data_i       (data),
        .sel_i        (sel),
        .address_i    (addr),
        .burst_len_i  (burst_len),
        .WE_I         (we),
        .reply_i      (reply),
        .flit_o       (flit),
        .flit_valid_o (flit_valid),
        .flit_ready_i (flit_ready),
        .len_err_o    (len_err)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          err_cyc  = -1;
    int          xfer_cnt = 0;
    int          err_seen = 0;
    bit          ready_rand = 1'b0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_flit;
    logic [63:0] exp_q[$];
    logic [1:0]  xfer_type [0:4095];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference model: expected flit list of one message, from the packet format rules.
    task automatic model_push(input logic we_m, input logic reply_m, input logic [2:0] len_m,
                              input logic [31:0] addr_m, input logic [127:0] data_m,
                              input logic [15:0] sel_m);
        int unsigned len_s, nd;
        logic [63:0] f;
        logic [61:0] x;
        len_s = (len_m > 3'd4) ? 4 : int'(len_m);
        nd    = (we_m || reply_m) ? len_s : 0;
        f = '0;
        f[63:62] = (nd == 0 && CHK == 0) ? 2'b11 : 2'b10;
        f[61]    = we_m;
        f[60]    = reply_m;
        f[59:57] = 3'(len_s);
        f[31:0]  = addr_m;
        exp_q.push_back(f);
        x = f[61:0];
        for (int unsigned k = 0; k < nd; k++) begin
            f = '0;
            f[63:62] = (k == nd - 1 && CHK == 0) ? 2'b01 : 2'b00;
            f[35:32] = sel_m[4*k +: 4];
            f[31:0]  = data_m[32*k +: 32];
            exp_q.push_back(f);
            x = x ^ f[61:0];
        end
        if (CHK != 0) exp_q.push_back({2'b01, x});
    endtask

    // Offer a message, wait (bounded) for acceptance, then scramble the inputs.
    task automatic send_msg(input logic we_m, input logic reply_m, input logic [2:0] len_m,
                            input logic [31:0] addr_m, input logic [127:0] data_m,
                            input logic [15:0] sel_m);
        bit got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (msg_ready) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL accept_timeout got=0 exp=1");
            return;
        end
        we = we_m; reply = reply_m; burst_len = len_m; addr = addr_m; data = data_m; sel = sel_m;
        msg_valid = 1'b1;
        model_push(we_m, reply_m, len_m, addr_m, data_m, sel_m);
        @(posedge clk);
        #1;
        msg_valid = 1'b0;
        if (len_m > 3'd4) err_cyc = cyc;
        we = 1'($urandom); reply = 1'($urandom); burst_len = 3'($urandom);
        addr = $urandom; sel = 16'($urandom);
        data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_drain(input int bound);
        bit done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !flit_valid) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d exp=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Output monitor: handshake rules, stall stability, len_err timing and flit contents.
    always @(negedge clk) begin
        if (rst_n) begin
            check64("ready_is_idle", 64'(msg_ready), 64'(!flit_valid));
            check64("len_err", 64'(len_err), 64'(cyc == err_cyc));
            if (prev_stall) begin
                check64("stall_valid", 64'(flit_valid), 64'd1);
                check64("stall_flit", flit, prev_flit);
            end
            if (flit_valid && flit_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_flit got=%h exp=none", flit);
                end else begin
                    check64("flit", flit, exp_q.pop_front());
                end
                if (xfer_cnt < 4096) xfer_type[xfer_cnt] = flit[63:62];
                xfer_cnt++;
            end
            if (len_err) err_seen++;
            prev_stall = flit_valid && !flit_ready;
            prev_flit  = flit;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Random backpressure driven just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_rand) flit_ready = ($urandom_range(0, 3) != 0);
        end
    end

    typedef struct {
        logic       we;
        logic       reply;
        logic [2:0] len;
        logic [31:0] addr;
        int         nflits;
        logic [1:0] htype;
        int         nerr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int          x0, e0;
        logic [63:0] hdr6, body6;

        // Expectations for the default build; checksum build adjusted below.
        vecs[0] = '{1'b1, 1'b0, 3'd4, 32'h0000_0100, 5, 2'b10, 0};
        vecs[1] = '{1'b0, 1'b0, 3'd2, 32'h0000_0200, 1, 2'b11, 0};
        vecs[2] = '{1'b0, 1'b1, 3'd3, 32'h0000_0300, 4, 2'b10, 0};
        vecs[3] = '{1'b1, 1'b0, 3'd7, 32'h0000_0400, 5, 2'b10, 1};
        vecs[4] = '{1'b1, 1'b0, 3'd0, 32'h0000_0500, 1, 2'b11, 0};
        vecs[5] = '{1'b0, 1'b0, 3'd7, 32'h0000_0600, 1, 2'b11, 1};
        vecs[6] = '{1'b1, 1'b1, 3'd1, 32'h0000_0700, 2, 2'b10, 0};
        vecs[7] = '{1'b0, 1'b0, 3'd5, 32'h0000_0800, 1, 2'b11, 1};
        for (int i = 0; i < 8; i++) begin
            vecs[i].nflits = vecs[i].nflits + CHK;
            vecs[i].htype  = (CHK != 0) ? 2'b10 : vecs[i].htype;
        end

        rst_n = 1'b0; msg_valid = 1'b0; flit_ready = 1'b0;
        data = '0; sel = '0; addr = '0; burst_len = '0; we = 1'b0; reply = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check64("rst_flit", flit, 64'd0);
        check64("rst_valid", 64'(flit_valid), 64'd0);
        check64("rst_ready", 64'(msg_ready), 64'd1);
        check64("rst_len_err", 64'(len_err), 64'd0);
        #2 rst_n = 1'b1;
        flit_ready = 1'b1;

        // T1: write burst of 4, one flit per cycle.
        send_msg(1'b1, 1'b0, 3'd4, 32'h0000_1000,
                 {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 16'hFFFF);
        for (int i = 0; i < 5 + CHK; i++) begin
            @(negedge clk);
            check64("t1_streaming", 64'(flit_valid), 64'd1);
            if (i == 0) check64("t1_header", flit, 64'hA800_0000_0000_1000);
            if (i == 1) check64("t1_body0", flit, 64'h0000_000F_0000_00A0);
        end
        @(negedge clk);
        check64("t1_done", 64'(flit_valid), 64'd0);
        wait_drain(20);

        // T2: read request, header only.
        send_msg(1'b0, 1'b0, 3'd2, 32'h0000_2000, 128'h0, 16'h0);
        @(negedge clk);
        check64("t2_header", flit, (CHK != 0) ? 64'h8400_0000_0000_2000
                                              : 64'hC400_0000_0000_2000);
        @(negedge clk);
        check64("t2_after_head", 64'(flit_valid), 64'(CHK));
        wait_drain(20);

        // Directed table, full-rate downstream.
        for (int i = 0; i < 8; i++) begin
            x0 = xfer_cnt;
            e0 = err_seen;
            send_msg(vecs[i].we, vecs[i].reply, vecs[i].len, vecs[i].addr,
                     {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
            wait_drain(50);
            check64("vec_nflits", 64'(xfer_cnt - x0), 64'(vecs[i].nflits));
            check64("vec_htype", 64'(xfer_type[x0]), 64'(vecs[i].htype));
            check64("vec_len_err", 64'(err_seen - e0), 64'(vecs[i].nerr));
        end

        // T3: reply of 3 words, 3 stall cycles on the second flit.
        x0 = xfer_cnt;
        send_msg(1'b0, 1'b1, 3'd3, 32'h0000_3000,
                 {32'h0, 32'hC2, 32'hC1, 32'hC0}, 16'h0ABC);
        @(posedge clk);
        #1 flit_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 flit_ready = 1'b1;
        for (int i = 0; i < 3 + CHK; i++) begin
            @(negedge clk);
            check64("t3_busy", 64'(msg_ready), 64'd0);
        end
        @(negedge clk);
        check64("t3_idle", 64'(msg_ready), 64'd1);
        wait_drain(20);
        check64("t3_nflits", 64'(xfer_cnt - x0), 64'(4 + CHK));

        // T5: reset during the second BODY flit aborts the packet.
        send_msg(1'b1, 1'b0, 3'd4, 32'h0000_5000, {4{32'h5555_AAAA}}, 16'hFFFF);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check64("t5_valid", 64'(flit_valid), 64'd0);
        check64("t5_ready", 64'(msg_ready), 64'd1);
        exp_q.delete();
        err_cyc = -1;
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        send_msg(1'b0, 1'b0, 3'd1, 32'h0000_5100, 128'h0, 16'h0);
        @(negedge clk);
        check64("t5_restart_valid", 64'(flit_valid), 64'd1);
        check64("t5_restart_type", 64'(flit[63:62]), (CHK != 0) ? 64'd2 : 64'd3);
        wait_drain(20);

`ifdef MSG2PKT_CHECKSUM_EN
        // T6: checksum flit of a one-word write.
        hdr6  = {2'b10, 1'b1, 1'b0, 3'd1, 25'd0, 32'h0000_6000};
        body6 = {2'b00, 26'd0, 4'hF, 32'h1234_5678};
        send_msg(1'b1, 1'b0, 3'd1, 32'h0000_6000, {96'h0, 32'h1234_5678}, 16'h000F);
        repeat (3) @(negedge clk);
        check64("t6_chk", flit, {2'b01, hdr6[61:0] ^ body6[61:0]});
        wait_drain(20);
`else
        hdr6  = '0;
        body6 = '0;
`endif

        // Randomized traffic with random backpressure.
        ready_rand = 1'b1;
        for (int n = 0; n < 60; n++) begin
            send_msg(1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)), $urandom,
                     {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        wait_drain(3000);
        ready_rand = 1'b0;
        flit_ready = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
